// File: rtl/dbg_loader.sv
// Debug/load initiator: decodes a UART byte protocol into core debug-port
// accesses (memory writes, halt/go/step, read-back) and returns response bytes.
module dbg_loader #(
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] addr,
   output logic [31:0] din,
   output logic        we_im,
   output logic        we_dm,
   output logic        debug,
   output logic        step,
   input  logic [31:0] dout_im,
   input  logic [31:0] dout_dm,
   input  logic [31:0] dout_rf
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [7:0] CMD_WIM  = 8'h49;
   localparam logic [7:0] CMD_WDM  = 8'h44;
   localparam logic [7:0] CMD_RIM  = 8'h69;
   localparam logic [7:0] CMD_RDM  = 8'h64;
   localparam logic [7:0] CMD_RRF  = 8'h72;
   localparam logic [7:0] CMD_HALT = 8'h48;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h45;
   localparam logic [7:0] RSP_UNK  = 8'h3F;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, EXEC, RD_WAIT, SEND, RESP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cmd_q;
   logic [1:0]    cnt_q;
   logic [TW-1:0] idle_q;
   logic [31:0]   shreg_q;
   logic [7:0]    resp_byte;
   logic          in_fire, out_fire, timed_out, cmd_is_write;

   assign in_ready     = !rst && (state_q == IDLE || state_q == ADDR || state_q == DATA);
   assign in_fire      = in_valid && in_ready;
   assign out_fire     = out_valid && out_ready;
   assign timed_out    = (idle_q == TW'(TIMEOUT - 1));
   assign cmd_is_write = (cmd_q == CMD_WIM) || (cmd_q == CMD_WDM);
   assign out_data     = shreg_q[7:0];

   // NOTE: state/data registers use <= so every flop samples pre-edge values;
   // blocking here would make results depend on process ordering.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      we_im     = 1'b0;
      we_dm     = 1'b0;
      step      = 1'b0;
      resp_byte = RSP_OK;
      case (state_q)
         IDLE: if (in_fire) begin
            case (in_data)
               CMD_WIM, CMD_WDM, CMD_RIM, CMD_RDM, CMD_RRF: state_d = ADDR;
               CMD_HALT, CMD_GO, CMD_STEP:                  state_d = EXEC;
               default:                                     state_d = RESP;
            endcase
         end
         ADDR: begin
            if (in_fire && cnt_q == 2'd3) state_d = cmd_is_write ? DATA : RD_WAIT;
            else if (!in_fire && timed_out) state_d = IDLE;
         end
         DATA: begin
            if (in_fire && cnt_q == 2'd3) state_d = EXEC;
            else if (!in_fire && timed_out) state_d = IDLE;
         end
         EXEC: begin
            state_d = RESP;
            case (cmd_q)
               CMD_WIM:  if (debug) we_im = 1'b1; else resp_byte = RSP_ERR;
               CMD_WDM:  if (debug) we_dm = 1'b1; else resp_byte = RSP_ERR;
               CMD_STEP: if (debug) step  = 1'b1; else resp_byte = RSP_ERR;
               default:  resp_byte = RSP_OK;
            endcase
         end
         RD_WAIT: state_d = SEND;
         SEND:    if (out_fire && cnt_q == 2'd3) state_d = IDLE;
         RESP:    if (out_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A strobe landing in a reset cycle must never reach the core.
      if (rst) begin
         we_im = 1'b0;
         we_dm = 1'b0;
         step  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q     <= '0;
         cnt_q     <= '0;
         idle_q    <= '0;
         shreg_q   <= '0;
         out_valid <= 1'b0;
         debug     <= 1'b1;
         addr      <= '0;
         din       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               idle_q <= '0;
               if (in_fire) begin
                  cmd_q <= in_data;
                  if (state_d == RESP) begin
                     shreg_q   <= {24'd0, RSP_UNK};
                     out_valid <= 1'b1;
                  end
               end
            end
            ADDR, DATA: begin
               if (in_fire) begin
                  idle_q <= '0;
                  cnt_q  <= cnt_q + 2'd1;
                  if (state_q == ADDR) addr <= {in_data, addr[31:8]};
                  else                 din  <= {in_data, din[31:8]};
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            EXEC: begin
               shreg_q   <= {24'd0, resp_byte};
               out_valid <= 1'b1;
               if (cmd_q == CMD_HALT) debug <= 1'b1;
               if (cmd_q == CMD_GO)   debug <= 1'b0;
            end
            RD_WAIT: begin
               case (cmd_q)
                  CMD_RIM: shreg_q <= dout_im;
                  CMD_RDM: shreg_q <= dout_dm;
                  default: shreg_q <= dout_rf;
               endcase
               out_valid <= 1'b1;
               cnt_q     <= '0;
            end
            SEND: if (out_fire) begin
               shreg_q <= {8'd0, shreg_q[31:8]};
               cnt_q   <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) out_valid <= 1'b0;
            end
            RESP: if (out_fire) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
